// File: rtl/sound_square_channel.sv
// rtl/sound_square_channel.sv - GBC square-wave voice with optional frequency sweep
// Decodes its own NRx0-NRx4 writes and runs an internal 512 Hz frame sequencer.
module sound_square_channel #(
  parameter logic [15:0] BASE_ADDR = 16'hFF10,
  parameter int          HAS_SWEEP = 1,
  parameter int          FS_DIV    = 64453,
  parameter int          FREQ_DIV  = 32
) (
  input  logic        I_CLK_33MHZ,
  input  logic        I_RESET,
  input  logic [15:0] I_IOREG_ADDR,
  input  logic [7:0]  I_IOREG_DATA,
  input  logic        I_IOREG_WE_L,
  output logic [3:0]  O_SAMPLE,
  output logic        O_ENABLED
);

  localparam int FS_W = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
  localparam int FD_W = (FREQ_DIV > 1) ? $clog2(FREQ_DIV) : 1;
  localparam logic [FS_W-1:0] FS_LAST = FS_W'(FS_DIV - 1);
  localparam logic [FS_W-1:0] FS_ONE  = FS_W'(1);
  localparam logic [FD_W-1:0] FD_LAST = FD_W'(FREQ_DIV - 1);
  localparam logic [FD_W-1:0] FD_ONE  = FD_W'(1);

  // Bit 11 of the result flags a sum above 2047 (overflow).
  function automatic logic [11:0] sweep_calc(input logic [10:0] f,
                                             input logic        negate,
                                             input logic [2:0]  shift);
    logic [11:0] base;
    logic [11:0] delta;
    base  = {1'b0, f};
    delta = base >> shift;
    return negate ? (base - delta) : (base + delta);
  endfunction

  logic [6:0]      nr0_q, nr0_d;
  logic [1:0]      duty_q, duty_d;
  logic [7:0]      nr2_q, nr2_d;
  logic [10:0]     freq_q, freq_d;
  logic            len_en_q, len_en_d;
  logic            enabled_q, enabled_d;
  logic [6:0]      length_ctr_q, length_ctr_d;
  logic [11:0]     freq_timer_q, freq_timer_d;
  logic [2:0]      duty_pos_q, duty_pos_d;
  logic [3:0]      volume_q, volume_d;
  logic [2:0]      env_timer_q, env_timer_d;
  logic [10:0]     shadow_q, shadow_d;
  logic [3:0]      sweep_timer_q, sweep_timer_d;
  logic            sweep_en_q, sweep_en_d;
  logic [FS_W-1:0] fs_cnt_q, fs_cnt_d;
  logic [FD_W-1:0] fd_cnt_q, fd_cnt_d;
  logic [2:0]      fs_step_q, fs_step_d;
  logic [3:0]      sample_q, sample_d;

  logic            fs_tick;
  logic            fd_tick;
  logic            wr_en;
  logic [2:0]      sweep_period;
  logic [3:0]      sweep_reload;
  logic [11:0]     sweep_new;
  logic [11:0]     sweep_chk;
  logic [11:0]     trig_chk;
  logic [7:0]      duty_pat;

  always_comb begin
    nr0_d         = nr0_q;
    duty_d        = duty_q;
    nr2_d         = nr2_q;
    freq_d        = freq_q;
    len_en_d      = len_en_q;
    enabled_d     = enabled_q;
    length_ctr_d  = length_ctr_q;
    freq_timer_d  = freq_timer_q;
    duty_pos_d    = duty_pos_q;
    volume_d      = volume_q;
    env_timer_d   = env_timer_q;
    shadow_d      = shadow_q;
    sweep_timer_d = sweep_timer_q;
    sweep_en_d    = sweep_en_q;
    trig_chk      = 12'd0;

    fs_tick   = (fs_cnt_q == FS_LAST);
    fd_tick   = (fd_cnt_q == FD_LAST);
    fs_cnt_d  = fs_tick ? '0 : (fs_cnt_q + FS_ONE);
    fd_cnt_d  = fd_tick ? '0 : (fd_cnt_q + FD_ONE);
    fs_step_d = fs_tick ? (fs_step_q + 3'd1) : fs_step_q;
    wr_en     = !I_IOREG_WE_L;

    sweep_period = nr0_q[6:4];
    sweep_reload = (sweep_period == 3'd0) ? 4'd8 : {1'b0, sweep_period};
    sweep_new    = sweep_calc(shadow_q, nr0_q[3], nr0_q[2:0]);
    sweep_chk    = sweep_calc(sweep_new[10:0], nr0_q[3], nr0_q[2:0]);

    if (fd_tick) begin
      if (freq_timer_q <= 12'd1) begin
        freq_timer_d = 12'd2048 - {1'b0, freq_q};
        duty_pos_d   = duty_pos_q + 3'd1;
      end else begin
        freq_timer_d = freq_timer_q - 12'd1;
      end
    end

    // Frame-sequencer actions see pre-write register values; writes below override.
    if (fs_tick) begin
      if (!fs_step_q[0] && len_en_q && (length_ctr_q != 7'd0)) begin
        length_ctr_d = length_ctr_q - 7'd1;
        if (length_ctr_q == 7'd1) enabled_d = 1'b0;
      end

      if ((HAS_SWEEP != 0) && (fs_step_q[1:0] == 2'b10)) begin
        if (sweep_timer_q <= 4'd1) begin
          sweep_timer_d = sweep_reload;
          if (sweep_en_q && (sweep_period != 3'd0)) begin
            if (sweep_new[11]) begin
              enabled_d = 1'b0;
            end else if (nr0_q[2:0] != 3'd0) begin
              shadow_d = sweep_new[10:0];
              freq_d   = sweep_new[10:0];
              if (sweep_chk[11]) enabled_d = 1'b0;
            end
          end
        end else begin
          sweep_timer_d = sweep_timer_q - 4'd1;
        end
      end

      if ((fs_step_q == 3'd7) && (nr2_q[2:0] != 3'd0)) begin
        if (env_timer_q <= 3'd1) begin
          env_timer_d = nr2_q[2:0];
          if (nr2_q[3] && (volume_q != 4'hF)) begin
            volume_d = volume_q + 4'd1;
          end else if (!nr2_q[3] && (volume_q != 4'h0)) begin
            volume_d = volume_q - 4'd1;
          end
        end else begin
          env_timer_d = env_timer_q - 3'd1;
        end
      end
    end

    if (wr_en) begin
      if ((HAS_SWEEP != 0) && (I_IOREG_ADDR == BASE_ADDR)) begin
        nr0_d = I_IOREG_DATA[6:0];
      end
      if (I_IOREG_ADDR == (BASE_ADDR + 16'd1)) begin
        duty_d       = I_IOREG_DATA[7:6];
        length_ctr_d = 7'd64 - {1'b0, I_IOREG_DATA[5:0]};
      end
      if (I_IOREG_ADDR == (BASE_ADDR + 16'd2)) begin
        nr2_d = I_IOREG_DATA;
        if (I_IOREG_DATA[7:3] == 5'd0) enabled_d = 1'b0;
      end
      if (I_IOREG_ADDR == (BASE_ADDR + 16'd3)) begin
        freq_d[7:0] = I_IOREG_DATA;
      end
      if (I_IOREG_ADDR == (BASE_ADDR + 16'd4)) begin
        freq_d[10:8] = I_IOREG_DATA[2:0];
        len_en_d     = I_IOREG_DATA[6];
        if (I_IOREG_DATA[7]) begin
          enabled_d = (nr2_q[7:3] != 5'd0);
          if (length_ctr_d == 7'd0) length_ctr_d = 7'd64;
          freq_timer_d = 12'd2048 - {1'b0, freq_d};
          volume_d     = nr2_q[7:4];
          env_timer_d  = nr2_q[2:0];
          if (HAS_SWEEP != 0) begin
            shadow_d      = freq_d;
            sweep_timer_d = sweep_reload;
            sweep_en_d    = (sweep_period != 3'd0) || (nr0_q[2:0] != 3'd0);
            trig_chk      = sweep_calc(freq_d, nr0_q[3], nr0_q[2:0]);
            if ((nr0_q[2:0] != 3'd0) && trig_chk[11]) enabled_d = 1'b0;
          end
        end
      end
    end

    case (duty_q)
      2'b00:   duty_pat = 8'b0000_0001;
      2'b01:   duty_pat = 8'b1000_0001;
      2'b10:   duty_pat = 8'b1000_0111;
      default: duty_pat = 8'b0111_1110;
    endcase
    sample_d = (enabled_q && duty_pat[duty_pos_q]) ? volume_q : 4'd0;
  end

  always_ff @(posedge I_CLK_33MHZ) begin
    if (I_RESET) begin
      nr0_q         <= '0;
      duty_q        <= '0;
      nr2_q         <= '0;
      freq_q        <= '0;
      len_en_q      <= 1'b0;
      enabled_q     <= 1'b0;
      length_ctr_q  <= '0;
      freq_timer_q  <= '0;
      duty_pos_q    <= '0;
      volume_q      <= '0;
      env_timer_q   <= '0;
      shadow_q      <= '0;
      sweep_timer_q <= '0;
      sweep_en_q    <= 1'b0;
      fs_cnt_q      <= '0;
      fd_cnt_q      <= '0;
      fs_step_q     <= '0;
      sample_q      <= '0;
    end else begin
      nr0_q         <= nr0_d;
      duty_q        <= duty_d;
      nr2_q         <= nr2_d;
      freq_q        <= freq_d;
      len_en_q      <= len_en_d;
      enabled_q     <= enabled_d;
      length_ctr_q  <= length_ctr_d;
      freq_timer_q  <= freq_timer_d;
      duty_pos_q    <= duty_pos_d;
      volume_q      <= volume_d;
      env_timer_q   <= env_timer_d;
      shadow_q      <= shadow_d;
      sweep_timer_q <= sweep_timer_d;
      sweep_en_q    <= sweep_en_d;
      fs_cnt_q      <= fs_cnt_d;
      fd_cnt_q      <= fd_cnt_d;
      fs_step_q     <= fs_step_d;
      sample_q      <= sample_d;
    end
  end

  assign O_SAMPLE  = sample_q;
  assign O_ENABLED = enabled_q;

endmodule
